// File: rtl/mci_mcu_trace_buffer_pkg.sv
// Shared types for the MCU trace buffer: DMI register image, trace packet and unloader states.
package mci_mcu_trace_buffer_pkg;

   localparam int MCI_MCU_TRACE_PACKET_NUM_DWORDS = 4;
   localparam int MCI_MCU_TRACE_RD_SETTLE_CYCLES  = 2;

   // Dword 0 occupies bits [31:0] of the packet.
   typedef logic [MCI_MCU_TRACE_PACKET_NUM_DWORDS-1:0][31:0] mci_mcu_trace_packet_t;

   typedef struct packed {
      logic [31:0] trace_status;
      logic [31:0] trace_config;
      logic [31:0] trace_wr_ptr;
      logic [31:0] trace_rd_ptr;
      logic [31:0] trace_data;
   } mci_mcu_trace_buffer_dmi_reg_t;

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      SET_PTR,
      SETTLE,
      CAPTURE,
      PRESENT,
      FINISH
   } mci_mcu_trace_unloader_state_e;

endpackage

// File: rtl/mci_mcu_trace_unloader.sv
// Drains the MCU trace buffer over DMI: programs TRACE_RD_PTR, waits for TRACE_DATA to settle,
// and packs four dwords at a time into packets handed to a valid/ready sink.
module mci_mcu_trace_unloader
   import mci_mcu_trace_buffer_pkg::*;
#(
   parameter logic [6:0] DMI_REG_TRACE_RD_PTR_ADDR = 7'h5D,
   parameter int         RD_SETTLE_CYCLES          = MCI_MCU_TRACE_RD_SETTLE_CYCLES
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          debug_en,
   input  logic                          start,
   input  logic                          abort,
   input  mci_mcu_trace_buffer_dmi_reg_t dmi_reg,
   output logic                          dmi_reg_wen,
   output logic [6:0]                    dmi_reg_addr,
   output logic [31:0]                   dmi_reg_wdata,
   output logic                          pkt_valid,
   input  logic                          pkt_ready,
   output mci_mcu_trace_packet_t         pkt_data,
   output logic                          pkt_last,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic                          overrun
);

   // Final value of the settle counter before moving to CAPTURE.
   localparam logic [7:0] SETTLE_LAST = (RD_SETTLE_CYCLES > 1) ? 8'(RD_SETTLE_CYCLES - 2) : 8'd0;

   mci_mcu_trace_unloader_state_e state_q, state_d;

   logic [31:0]           ptr_q, ptr_d;
   logic [31:0]           remaining_q, remaining_d;
   logic [31:0]           depth_q, depth_d;
   logic [31:0]           wr_snap_q, wr_snap_d;
   logic [7:0]            settle_q, settle_d;
   mci_mcu_trace_packet_t pkt_q, pkt_d;
   logic                  error_q, error_d;
   logic                  overrun_q, overrun_d;

   logic [31:0] ptr_inc;
   logic [31:0] start_ptr;
   logic [31:0] start_cnt;
   logic        valid_data;
   logic        wrapped;

   assign valid_data = dmi_reg.trace_status[0];
   assign wrapped    = dmi_reg.trace_status[1];

   logic unused_dmi;
   assign unused_dmi = ^{dmi_reg.trace_rd_ptr, dmi_reg.trace_status[31:2]};

   // NOTE: every always_comb target gets a default first so no path can leave it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      remaining_d = remaining_q;
      depth_d     = depth_q;
      wr_snap_d   = wr_snap_q;
      settle_d    = settle_q;
      pkt_d       = pkt_q;
      error_d     = error_q;
      overrun_d   = overrun_q;
      ptr_inc     = ptr_q + 32'd1;
      start_ptr   = wrapped ? dmi_reg.trace_wr_ptr : 32'd0;
      start_cnt   = wrapped ? dmi_reg.trace_config : dmi_reg.trace_wr_ptr;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (debug_en) begin
                  state_d   = CHECK;
                  error_d   = 1'b0;
                  overrun_d = 1'b0;
                  pkt_d     = '0;
               end else begin
                  error_d = 1'b1;
               end
            end
         end

         CHECK: begin
            wr_snap_d = dmi_reg.trace_wr_ptr;
            depth_d   = dmi_reg.trace_config;
            if (!valid_data) begin
               state_d = FINISH;
            end else if (dmi_reg.trace_config == 32'd0 || dmi_reg.trace_wr_ptr[1:0] != 2'd0) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               ptr_d       = start_ptr;
               remaining_d = start_cnt;
               state_d     = (start_cnt == 32'd0) ? FINISH : SET_PTR;
            end
         end

         SET_PTR: begin
            settle_d = 8'd0;
            state_d  = (RD_SETTLE_CYCLES > 1) ? SETTLE : CAPTURE;
         end

         SETTLE: begin
            if (settle_q == SETTLE_LAST) begin
               state_d = CAPTURE;
            end else begin
               settle_d = settle_q + 8'd1;
            end
         end

         CAPTURE: begin
            pkt_d[ptr_q[1:0]] = dmi_reg.trace_data;
            ptr_d             = (ptr_inc >= depth_q) ? 32'd0 : ptr_inc;
            remaining_d       = remaining_q - 32'd1;
            // A short final packet is still presented once the count runs out.
            state_d = (ptr_q[1:0] == 2'd3 || remaining_q == 32'd1) ? PRESENT : SET_PTR;
         end

         PRESENT: begin
            if (pkt_ready) begin
               pkt_d   = '0;
               state_d = (remaining_q != 32'd0) ? SET_PTR : FINISH;
            end
         end

         FINISH: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Faults that apply to every active state; these override the per-state decisions above.
      if (state_q != IDLE) begin
         if (state_q != CHECK && dmi_reg.trace_wr_ptr != wr_snap_q) begin
            overrun_d = 1'b1;
         end
         if (!debug_en) begin
            error_d = 1'b1;
            state_d = IDLE;
         end else if (abort) begin
            error_d = error_q;
            state_d = IDLE;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         remaining_q <= '0;
         depth_q     <= '0;
         wr_snap_q   <= '0;
         settle_q    <= '0;
         pkt_q       <= '0;
         error_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         remaining_q <= remaining_d;
         depth_q     <= depth_d;
         wr_snap_q   <= wr_snap_d;
         settle_q    <= settle_d;
         pkt_q       <= pkt_d;
         error_q     <= error_d;
         overrun_q   <= overrun_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign dmi_reg_wen   = (state_q == SET_PTR);
   assign dmi_reg_addr  = dmi_reg_wen ? DMI_REG_TRACE_RD_PTR_ADDR : 7'd0;
   assign dmi_reg_wdata = dmi_reg_wen ? ptr_q : 32'd0;
   assign pkt_valid     = (state_q == PRESENT);
   assign pkt_last      = pkt_valid && (remaining_q == 32'd0);
   assign pkt_data      = pkt_q;
   assign error         = error_q;
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_mci_mcu_trace_unloader.sv
// Directed bench for the trace unloader; a small trace buffer model answers RD_PTR writes
// with TRACE_DATA = {16'hC0DE, rd_ptr[15:0]} two cycles after the write.
module tb_mci_mcu_trace_unloader;
   import mci_mcu_trace_buffer_pkg::*;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic debug_en  = 1'b1;
   logic start     = 1'b0;
   logic abort     = 1'b0;
   logic pkt_ready = 1'b1;

   mci_mcu_trace_buffer_dmi_reg_t dmi_reg;
   logic                  dmi_reg_wen;
   logic [6:0]            dmi_reg_addr;
   logic [31:0]           dmi_reg_wdata;
   logic                  pkt_valid;
   mci_mcu_trace_packet_t pkt_data;
   logic                  pkt_last, busy, done, error, overrun;

   logic [31:0] st_reg   = 32'd0;
   logic [31:0] cfg_reg  = 32'd256;
   logic [31:0] wrp_reg  = 32'd8;
   logic [31:0] m_rd_ptr = 32'd0;
   int          m_age    = 0;

   int checks   = 0;
   int failures = 0;
   int addr_bad = 0;
   int done_cnt, done_cyc, last_pkt_cyc, end_cyc;
   bit timed_out;

   mci_mcu_trace_packet_t pkt_q[$];
   logic                  last_q[$];
   logic [31:0]           wr_log[$];

   always #5 clk = ~clk;

   mci_mcu_trace_unloader dut (
      .clk(clk), .rst(rst), .debug_en(debug_en), .start(start), .abort(abort),
      .dmi_reg(dmi_reg), .dmi_reg_wen(dmi_reg_wen), .dmi_reg_addr(dmi_reg_addr),
      .dmi_reg_wdata(dmi_reg_wdata), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_data(pkt_data), .pkt_last(pkt_last), .busy(busy), .done(done),
      .error(error), .overrun(overrun)
   );

   always_comb begin
      dmi_reg.trace_status = st_reg;
      dmi_reg.trace_config = cfg_reg;
      dmi_reg.trace_wr_ptr = wrp_reg;
      dmi_reg.trace_rd_ptr = m_rd_ptr;
      dmi_reg.trace_data   = (m_age >= 1) ? {16'hC0DE, m_rd_ptr[15:0]} : 32'hBAD0_BAD0;
   end

   // Trace buffer model: data is only valid RD_SETTLE_CYCLES after the pointer write.
   always @(posedge clk) begin
      if (rst) begin
         m_rd_ptr <= 32'd0;
         m_age    <= 0;
      end else if (dmi_reg_wen && dmi_reg_addr == 7'h5D) begin
         m_rd_ptr <= dmi_reg_wdata;
         m_age    <= 0;
      end else if (m_age < 3) begin
         m_age <= m_age + 1;
      end
   end

   always @(negedge clk) begin
      if (dmi_reg_wen) begin
         wr_log.push_back(dmi_reg_wdata);
         if (dmi_reg_addr !== 7'h5D) addr_bad++;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      wr_log.delete();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Runs until busy drops; cycle 1 (CHECK) has already elapsed inside start_pulse.
   task automatic collect(input int budget);
      pkt_q.delete();
      last_q.delete();
      done_cnt     = 0;
      done_cyc     = -1;
      last_pkt_cyc = -1;
      end_cyc      = -1;
      timed_out    = 1'b1;
      for (int c = 2; c <= budget; c++) begin
         tick();
         if (pkt_valid && pkt_ready) begin
            pkt_q.push_back(pkt_data);
            last_q.push_back(pkt_last);
            last_pkt_cyc = c;
         end
         if (done) begin
            done_cnt++;
            done_cyc = c;
         end
         if (!busy) begin
            end_cyc   = c;
            timed_out = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (pkt_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, error, overrun, pkt_valid, pkt_last, dmi_reg_wen} !== 7'd0) begin
         failures++;
         $display("FAIL reset_flags: got %b expected 0000000", {busy, done, error, overrun, pkt_valid, pkt_last, dmi_reg_wen});
      end
      checks++;
      if (pkt_data !== 128'd0 || dmi_reg_addr !== 7'd0 || dmi_reg_wdata !== 32'd0) begin
         failures++;
         $display("FAIL reset_data: got pkt=%h addr=%h wdata=%h expected all zero", pkt_data, dmi_reg_addr, dmi_reg_wdata);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_not_wrapped();
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b1;
      start_pulse();
      collect(100);
      checks++;
      if (timed_out || pkt_q.size() != 2) begin
         failures++;
         $display("FAIL nowrap_count: got %0d packets (timeout=%0b) expected 2", pkt_q.size(), timed_out);
      end
      if (pkt_q.size() == 2) begin
         checks++;
         if (pkt_q[0] !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
            failures++;
            $display("FAIL nowrap_pkt0: got %h expected C0DE0003C0DE0002C0DE0001C0DE0000", pkt_q[0]);
         end
         checks++;
         if (pkt_q[1] !== 128'hC0DE0007_C0DE0006_C0DE0005_C0DE0004) begin
            failures++;
            $display("FAIL nowrap_pkt1: got %h expected C0DE0007C0DE0006C0DE0005C0DE0004", pkt_q[1]);
         end
         checks++;
         if ({last_q[0], last_q[1]} !== 2'b01) begin
            failures++;
            $display("FAIL nowrap_last: got %b expected 01", {last_q[0], last_q[1]});
         end
      end
      checks++;
      if (last_pkt_cyc != 27 || done_cyc != 28 || done_cnt != 1) begin
         failures++;
         $display("FAIL nowrap_timing: got last_pkt=%0d done=%0d ndone=%0d expected 27 28 1", last_pkt_cyc, done_cyc, done_cnt);
      end
      checks++;
      if (wr_log.size() != 8 || addr_bad != 0) begin
         failures++;
         $display("FAIL nowrap_dmi_writes: got %0d writes %0d bad addr expected 8 0", wr_log.size(), addr_bad);
      end else begin
         for (int i = 0; i < 8; i++) begin
            checks++;
            if (wr_log[i] !== 32'(i)) begin
               failures++;
               $display("FAIL nowrap_rd_ptr: got %0d expected %0d", wr_log[i], i);
            end
         end
      end
   endtask

   task automatic test_wrapped();
      int nl;
      st_reg = 32'h3; cfg_reg = 32'd256; wrp_reg = 32'd252; pkt_ready = 1'b1;
      start_pulse();
      collect(900);
      checks++;
      if (timed_out || pkt_q.size() != 64 || done_cnt != 1) begin
         failures++;
         $display("FAIL wrap_count: got %0d packets %0d done expected 64 1", pkt_q.size(), done_cnt);
      end
      if (pkt_q.size() == 64) begin
         checks++;
         if (pkt_q[0] !== 128'hC0DE00FF_C0DE00FE_C0DE00FD_C0DE00FC) begin
            failures++;
            $display("FAIL wrap_pkt0: got %h expected C0DE00FFC0DE00FEC0DE00FDC0DE00FC", pkt_q[0]);
         end
         checks++;
         if (pkt_q[1] !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
            failures++;
            $display("FAIL wrap_pkt1: got %h expected C0DE0003C0DE0002C0DE0001C0DE0000", pkt_q[1]);
         end
         checks++;
         if (pkt_q[63] !== 128'hC0DE00FB_C0DE00FA_C0DE00F9_C0DE00F8) begin
            failures++;
            $display("FAIL wrap_pkt63: got %h expected C0DE00FBC0DE00FAC0DE00F9C0DE00F8", pkt_q[63]);
         end
         nl = 0;
         foreach (last_q[i]) nl += int'(last_q[i]);
         checks++;
         if (nl != 1 || last_q[63] !== 1'b1) begin
            failures++;
            $display("FAIL wrap_last: got %0d last flags (final=%b) expected 1 on final", nl, last_q[63]);
         end
      end
      checks++;
      if (wr_log.size() != 256 || wr_log[255] !== 32'd251) begin
         failures++;
         $display("FAIL wrap_end_ptr: got %0d writes ending at %0d expected 256 ending at 251", wr_log.size(), (wr_log.size() > 0) ? wr_log[wr_log.size()-1] : 32'hFFFF_FFFF);
      end
   endtask

   task automatic test_no_data();
      st_reg = 32'h0; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b1;
      start_pulse();
      collect(20);
      checks++;
      if (pkt_q.size() != 0 || wr_log.size() != 0) begin
         failures++;
         $display("FAIL nodata_packets: got %0d packets %0d writes expected 0 0", pkt_q.size(), wr_log.size());
      end
      checks++;
      if (done_cyc != 2 || done_cnt != 1 || end_cyc != 3) begin
         failures++;
         $display("FAIL nodata_done: got done at %0d (x%0d) idle at %0d expected 2 x1 3", done_cyc, done_cnt, end_cyc);
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int bad;
      int nwr;
      mci_mcu_trace_packet_t held;
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b0;
      start_pulse();
      wait_valid(40, ok);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_valid: got no pkt_valid expected valid within 40 cycles");
      end
      held = pkt_data;
      nwr  = wr_log.size();
      bad  = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (!pkt_valid || pkt_data !== held || dmi_reg_wen) bad++;
      end
      checks++;
      if (bad != 0 || wr_log.size() != nwr) begin
         failures++;
         $display("FAIL bp_stable: got %0d unstable cycles %0d extra writes expected 0 0", bad, wr_log.size() - nwr);
      end
      checks++;
      if (held !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
         failures++;
         $display("FAIL bp_data: got %h expected C0DE0003C0DE0002C0DE0001C0DE0000", held);
      end
      pkt_ready = 1'b1;
      tick();
      checks++;
      if (dmi_reg_wen !== 1'b1 || dmi_reg_wdata !== 32'd4) begin
         failures++;
         $display("FAIL bp_resume: got wen=%b wdata=%0d expected 1 4", dmi_reg_wen, dmi_reg_wdata);
      end
      collect(60);
      checks++;
      if (pkt_q.size() != 1 || done_cnt != 1 || wr_log.size() != 8) begin
         failures++;
         $display("FAIL bp_finish: got %0d packets %0d done %0d writes expected 1 1 8", pkt_q.size(), done_cnt, wr_log.size());
      end
   endtask

   task automatic test_debug_loss();
      int nd;
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b1;
      start_pulse();
      tick();
      tick();
      debug_en = 1'b0;
      tick();
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || pkt_valid !== 1'b0) begin
         failures++;
         $display("FAIL dbg_abort: got error=%b busy=%b valid=%b expected 1 0 0", error, busy, pkt_valid);
      end
      nd = int'(done);
      for (int i = 0; i < 3; i++) begin
         tick();
         nd += int'(done);
      end
      checks++;
      if (nd != 0) begin
         failures++;
         $display("FAIL dbg_no_done: got %0d done pulses expected 0", nd);
      end
      debug_en = 1'b1;
   endtask

   task automatic test_start_locked();
      st_reg = 32'h0;
      start_pulse();
      checks++;
      if (error !== 1'b0) begin
         failures++;
         $display("FAIL lock_error_clear: got %b expected 0", error);
      end
      collect(10);
      debug_en = 1'b0;
      start_pulse();
      checks++;
      if (error !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL lock_start: got error=%b busy=%b expected 1 0", error, busy);
      end
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL lock_idle: got busy=%b done=%b expected 0 0", busy, done);
      end
      debug_en = 1'b1;
   endtask

   task automatic test_overrun();
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b1;
      start_pulse();
      repeat (5) tick();
      wrp_reg = 32'd12;
      collect(100);
      checks++;
      if (overrun !== 1'b1 || error !== 1'b0) begin
         failures++;
         $display("FAIL ovr_flag: got overrun=%b error=%b expected 1 0", overrun, error);
      end
      checks++;
      if (pkt_q.size() != 2 || wr_log.size() != 8 || done_cnt != 1) begin
         failures++;
         $display("FAIL ovr_count: got %0d packets %0d writes %0d done expected 2 8 1", pkt_q.size(), wr_log.size(), done_cnt);
      end
      wrp_reg = 32'd8;
   endtask

   task automatic test_abort();
      bit ok;
      int nd;
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b1;
      start_pulse();
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL abort_ovr_clear: got %b expected 0", overrun);
      end
      repeat (4) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || error !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_mid: got busy=%b error=%b done=%b expected 0 0 0", busy, error, done);
      end
      nd = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         nd += int'(done);
      end
      checks++;
      if (nd != 0) begin
         failures++;
         $display("FAIL abort_no_done: got %0d done pulses expected 0", nd);
      end
      pkt_ready = 1'b0;
      start_pulse();
      wait_valid(40, ok);
      abort     = 1'b1;
      pkt_ready = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (!ok || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL abort_vs_handshake: got valid_seen=%b busy=%b done=%b expected 1 0 0", ok, busy, done);
      end
   endtask

   task automatic test_bad_config();
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd6; pkt_ready = 1'b1;
      start_pulse();
      tick();
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || wr_log.size() != 0) begin
         failures++;
         $display("FAIL cfg_misaligned: got error=%b busy=%b writes=%0d expected 1 0 0", error, busy, wr_log.size());
      end
      wrp_reg = 32'd8; cfg_reg = 32'd0;
      start_pulse();
      tick();
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || wr_log.size() != 0) begin
         failures++;
         $display("FAIL cfg_depth0: got error=%b busy=%b writes=%0d expected 1 0 0", error, busy, wr_log.size());
      end
      cfg_reg = 32'd256;
   endtask

   task automatic test_reset_mid_drain();
      bit ok;
      st_reg = 32'h1; cfg_reg = 32'd256; wrp_reg = 32'd8; pkt_ready = 1'b0;
      start_pulse();
      wait_valid(40, ok);
      rst = 1'b1;
      tick();
      checks++;
      if (!ok || pkt_valid !== 1'b0 || busy !== 1'b0 || pkt_data !== 128'd0 || error !== 1'b0) begin
         failures++;
         $display("FAIL rst_mid: got valid_seen=%b valid=%b busy=%b data=%h error=%b expected 1 0 0 0 0", ok, pkt_valid, busy, pkt_data, error);
      end
      rst       = 1'b0;
      pkt_ready = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL rst_after: got busy=%b done=%b expected 0 0", busy, done);
      end
   endtask

   initial begin
      test_reset();
      test_not_wrapped();
      test_wrapped();
      test_no_data();
      test_backpressure();
      test_debug_loss();
      test_start_locked();
      test_overrun();
      test_abort();
      test_bad_config();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mci_mcu_trace_unloader.md
MCI_MCU_TRACE_UNLOADER -- requirements
Module: mci_mcu_trace_unloader

Interface
REQ-001 SHALL have parameter DMI_REG_TRACE_RD_PTR_ADDR, default 7'h5D, DMI address of TRACE_RD_PTR.
REQ-002 SHALL have parameter RD_SETTLE_CYCLES, default 2, cycles from RD_PTR write to valid TRACE_DATA.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  reset; synchronous, active-high.
- debug_en  in  1  debug unlock qualifier.
- start  in  1  pulse; begin drain.
- abort  in  1  pulse; stop drain.
- dmi_reg  in  mci_mcu_trace_buffer_dmi_reg_t  TRACE_STATUS, TRACE_CONFIG, TRACE_WR_PTR, TRACE_RD_PTR, TRACE_DATA.
- dmi_reg_wen  out  1  DMI write strobe.
- dmi_reg_addr  out  7  DMI address.
- dmi_reg_wdata  out  32  DMI write data.
- pkt_valid  out  1  packet valid.
- pkt_ready  in  1  sink ready.
- pkt_data  out  mci_mcu_trace_packet_t (128)  trace packet, dword0 in bits [31:0].
- pkt_last  out  1  final packet of drain.
- busy  out  1  drain in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; cleared on next accepted start.
- overrun  out  1  sticky; TRACE_WR_PTR changed during drain.

Function
REQ-004 SHALL implement states IDLE, CHECK, SET_PTR, SETTLE, CAPTURE, PRESENT, FINISH.
REQ-005 IDLE: start with debug_en=1 -> CHECK, clear error/overrun; start with debug_en=0 -> set error, stay IDLE; start ignored when not IDLE.
REQ-006 CHECK (1 cycle): snapshot WR_PTR and depth (TRACE_CONFIG); TRACE_STATUS[0]=0 -> FINISH with zero packets.
REQ-007 Start pointer/count: TRACE_STATUS[1]=1 -> ptr=WR_PTR snapshot, dwords=depth; else ptr=0, dwords=WR_PTR snapshot.
REQ-008 SET_PTR: dmi_reg_wen=1, dmi_reg_addr=DMI_REG_TRACE_RD_PTR_ADDR, dmi_reg_wdata=ptr for exactly one cycle -> SETTLE.
REQ-009 SETTLE: count RD_SETTLE_CYCLES-1 cycles -> CAPTURE; CAPTURE samples TRACE_DATA into dword slot ptr[1:0] on that cycle.
REQ-010 After capture: ptr increments by 1, wraps to 0 when ptr+1 >= depth (32-bit compare); remaining dword count decrements.
REQ-011 Slot 3 captured -> PRESENT; else -> SET_PTR.
REQ-012 PRESENT: pkt_valid=1, pkt_data/pkt_last stable until pkt_valid&pkt_ready; pkt_last=1 iff remaining count=0.
REQ-013 Handshake in PRESENT: remaining>0 -> SET_PTR; remaining=0 -> FINISH.
REQ-014 FINISH: done=1 one cycle -> IDLE.
REQ-015 Per dword latency: 1+RD_SETTLE_CYCLES cycles; packet with immediate ready: 4*(1+RD_SETTLE_CYCLES)+1 cycles.
REQ-016 TRACE_WR_PTR != snapshot in any state other than IDLE -> overrun=1; drain continues.
REQ-017 debug_en=0 in any state other than IDLE -> error=1, pkt_valid drops, -> IDLE without done.
REQ-018 abort in any state other than IDLE -> IDLE next cycle, no done, no error; abort wins over same-cycle handshake.
REQ-019 busy=1 in all states except IDLE; dmi_reg_wen=0 outside SET_PTR.
REQ-020 depth=0 or WR_PTR snapshot not a multiple of 4 -> error=1, -> IDLE.

Reset
REQ-021 rst SHALL force IDLE; pkt_valid, pkt_last, pkt_data, dmi_reg_wen, dmi_reg_addr, dmi_reg_wdata, busy, done, error, overrun all 0; pointers/counters 0.
REQ-022 rst mid-drain SHALL take effect next clk edge, drop pkt_valid with no completion of the partial packet.

Structure
REQ-023 State enum and RD_SETTLE_CYCLES default SHALL live in mci_mcu_trace_buffer_pkg beside mci_mcu_trace_packet_t and MCI_MCU_TRACE_PACKET_NUM_DWORDS.
REQ-024 SHALL be a single module, no sub-modules.

Verification
REQ-025 Not wrapped, WR_PTR=8, depth=256 -> 2 packets, dword reads at ptr 0..7, pkt_last on 2nd, done 1 cycle later.
REQ-026 Wrapped, WR_PTR=252, depth=256 -> 64 packets, first from ptr 252..255, second from 0..3, last ends at ptr 251.
REQ-027 STATUS valid_data=0, start -> no pkt_valid, done pulse 2 cycles after start.
REQ-028 pkt_ready held 0 for 10 cycles in PRESENT -> pkt_data stable, no dmi_reg_wen until handshake.
REQ-029 debug_en deasserted during SETTLE -> error=1, busy=0 next cycle, no done; start with debug_en=0 -> error=1, busy stays 0.
REQ-030 WR_PTR advanced by 4 mid-drain -> overrun=1, packet count unchanged from snapshot; abort mid-packet -> IDLE next cycle, error=0.
